pwm_bank: RTL and testbench

//   Multi-channel PWM generator: NUM_CH independent duty-cycle outputs sharing one

---
 rtl/pwm_pkg.sv | 22 ++
 rtl/pwm_prescaler.sv | 38 +++
 rtl/pwm_bank.sv | 99 +++++++++
 tb/tb_pwm_bank.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_pkg
// Description : Shared types and constants for the pwm_bank PWM generator.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    localparam int c_def_width      = 8;
    localparam int c_def_prescale_w = 8;
    localparam logic [c_def_width-1:0] c_default_duty = 8'h7F;

    typedef logic [c_def_width-1:0]      duty_t;
    typedef logic [c_def_prescale_w-1:0] prescale_t;

    // A single channel still needs a 1-bit select port.
    function automatic int ch_idx_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : pwm_prescaler
// Description : Programmable clock-enable divider, one tick every value+1 clks.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_prescaler #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic [PRESCALE_W-1:0] i_value,
    output logic                  o_tick
);

    logic [PRESCALE_W-1:0] r_prescale;
    logic [PRESCALE_W-1:0] r_pre_cnt;

    assign o_tick = (r_pre_cnt == r_prescale);

    // A reload restarts the division phase but leaves the current tick intact.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prescale <= '0;
            r_pre_cnt  <= '0;
        end else if (i_load) begin
            r_prescale <= i_value;
            r_pre_cnt  <= '0;
        end else if (o_tick) begin
            r_pre_cnt  <= '0;
        end else begin
            r_pre_cnt  <= r_pre_cnt + PRESCALE_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pwm_bank.sv
`default_nettype none
// ============================================================================
// Module      : pwm_bank
// Description : NUM_CH-channel PWM with shared prescaler/period counter and
//               period-boundary double-buffered duty updates.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_bank
    import pwm_pkg::*;
#(
    parameter int               NUM_CH       = 4,
    parameter int               WIDTH        = 8,
    parameter int               PRESCALE_W   = 8,
    parameter logic [WIDTH-1:0] DEFAULT_DUTY = WIDTH'(c_default_duty)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_duty_we,
    input  logic [ch_idx_w(NUM_CH)-1:0]   i_duty_ch,
    input  logic [WIDTH-1:0]              i_duty_value,
    input  logic                          i_prescale_we,
    input  logic [PRESCALE_W-1:0]         i_prescale_value,
    input  logic [NUM_CH-1:0]             i_ch_enable,
    input  logic [NUM_CH-1:0]             i_ch_invert,
    output logic                          o_period_start,
    output logic [NUM_CH-1:0]             o_pwm_out
);

    localparam logic [WIDTH-1:0] c_per_max = '1;

    logic             w_tick;
    logic             w_wrap;
    logic [WIDTH-1:0] r_per_cnt;
    logic [WIDTH-1:0] w_per_next;
    logic             r_period_start;

    pwm_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .i_load  (i_prescale_we),
        .i_value (i_prescale_value),
        .o_tick  (w_tick)
    );

    always_comb begin
        w_per_next = w_tick ? (r_per_cnt + WIDTH'(1)) : r_per_cnt;
        w_wrap     = w_tick && (r_per_cnt == c_per_max);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_per_cnt      <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_per_cnt      <= w_per_next;
            r_period_start <= w_wrap;
        end
    end

    assign o_period_start = r_period_start;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            logic             w_sel;
            logic [WIDTH-1:0] w_shadow_next;
            logic [WIDTH-1:0] w_active_next;
            logic [WIDTH-1:0] r_shadow;
            logic [WIDTH-1:0] r_active;
            logic             r_pwm;

            // Out-of-range channel indices match no channel and are dropped.
            always_comb begin
                w_sel         = i_duty_we && (int'(i_duty_ch) == i);
                w_shadow_next = w_sel ? i_duty_value : r_shadow;
                w_active_next = w_wrap ? w_shadow_next : r_active;
            end

            // Compare against next-state values so the output lines up with per_cnt.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_shadow <= DEFAULT_DUTY;
                    r_active <= DEFAULT_DUTY;
                    r_pwm    <= 1'b0;
                end else begin
                    r_shadow <= w_shadow_next;
                    r_active <= w_active_next;
                    r_pwm    <= (i_ch_enable[i] && (w_per_next < w_active_next))
                                ^ i_ch_invert[i];
                end
            end

            assign o_pwm_out[i] = r_pwm;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pwm_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_bank
// Description : Scoreboard bench for pwm_bank with per-period duty measurements.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_bank;

    localparam int c_num_ch = 4;

    logic       clk;
    logic       reset;
    logic       duty_we;
    logic [1:0] duty_ch;
    logic [7:0] duty_value;
    logic       prescale_we;
    logic [7:0] prescale_value;
    logic [3:0] ch_enable;
    logic [3:0] ch_invert;
    logic       period_start;
    logic [3:0] pwm_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] pwm;
        logic       ps;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    int         m_pre;
    int         m_prescale;
    int         m_per;
    logic [7:0] m_shadow [c_num_ch];
    logic [7:0] m_active [c_num_ch];

    pwm_bank #(
        .NUM_CH       (4),
        .WIDTH        (8),
        .PRESCALE_W   (8),
        .DEFAULT_DUTY (8'h7F)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .i_duty_we        (duty_we),
        .i_duty_ch        (duty_ch),
        .i_duty_value     (duty_value),
        .i_prescale_we    (prescale_we),
        .i_prescale_value (prescale_value),
        .i_ch_enable      (ch_enable),
        .i_ch_invert      (ch_invert),
        .o_period_start   (period_start),
        .o_pwm_out        (pwm_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model advances one clock, expectation queued, then the edge is taken.
    task automatic step();
        exp_t e;
        bit   tick;
        bit   wrap;
        if (reset) begin
            m_pre = 0; m_prescale = 0; m_per = 0;
            for (int i = 0; i < c_num_ch; i++) begin
                m_shadow[i] = 8'h7F;
                m_active[i] = 8'h7F;
            end
            e.pwm = 4'b0000;
            e.ps  = 1'b0;
        end else begin
            tick = (m_pre == m_prescale);
            wrap = tick && (m_per == 255);
            if (prescale_we) begin
                m_prescale = int'(prescale_value);
                m_pre      = 0;
            end else begin
                m_pre = tick ? 0 : m_pre + 1;
            end
            if (tick) m_per = (m_per + 1) % 256;
            if (duty_we && int'(duty_ch) < c_num_ch) m_shadow[duty_ch] = duty_value;
            if (wrap) for (int i = 0; i < c_num_ch; i++) m_active[i] = m_shadow[i];
            for (int i = 0; i < c_num_ch; i++)
                e.pwm[i] = (ch_enable[i] && (m_per < int'(m_active[i]))) ^ ch_invert[i];
            e.ps = wrap;
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        duty_we     = 1'b0;
        prescale_we = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            total++;
            if (pwm_out !== mon_e.pwm || period_start !== mon_e.ps) begin
                bad++;
                $display("FAIL scoreboard t=%0t pwm_out=%b period_start=%b expected pwm_out=%b period_start=%b",
                         $time, pwm_out, period_start, mon_e.pwm, mon_e.ps);
            end
        end
    end

    task automatic wait_ps(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            if (period_start === 1'b1) begin
                ok = 1'b1;
                return;
            end
            step();
        end
    endtask

    // Called in a period_start cycle; counts high clocks until the next one.
    task automatic measure(output int hi [4], output int len);
        for (int i = 0; i < 4; i++) hi[i] = 0;
        len = 0;
        do begin
            for (int i = 0; i < 4; i++) hi[i] += int'(pwm_out[i]);
            step();
            len++;
        end while (period_start !== 1'b1 && len < 5000);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        total++;
        if (pwm_out !== 4'b0000) begin
            bad++; $display("FAIL reset_pwm got=%b exp=0000", pwm_out);
        end
        total++;
        if (period_start !== 1'b0) begin
            bad++; $display("FAIL reset_ps got=%b exp=0", period_start);
        end
        reset = 1'b0;
    endtask

    task automatic test_default_duty();
        bit ok;
        int hi [4];
        int len;
        wait_ps(ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL default_wait got=timeout exp=period_start"); end
        measure(hi, len);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (hi[i] !== 127) begin bad++; $display("FAIL default_high ch%0d got=%0d exp=127", i, hi[i]); end
        end
        total++;
        if (len !== 256) begin bad++; $display("FAIL default_period got=%0d exp=256", len); end
    endtask

    task automatic test_prescale();
        bit ok;
        int hi [4];
        int len;
        prescale_value = 8'd3; prescale_we = 1'b1;
        step();
        wait_ps(ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL prescale_wait got=timeout exp=period_start"); end
        measure(hi, len);
        total++;
        if (len !== 1024) begin bad++; $display("FAIL prescale_period1 got=%0d exp=1024", len); end
        total++;
        if (hi[0] !== 508) begin bad++; $display("FAIL prescale_high got=%0d exp=508", hi[0]); end
        measure(hi, len);
        total++;
        if (len !== 1024) begin bad++; $display("FAIL prescale_period2 got=%0d exp=1024", len); end
        prescale_value = 8'd0; prescale_we = 1'b1;
        step();
    endtask

    task automatic test_mid_write();
        bit ok;
        int hi [4];
        int len;
        wait_ps(ok);
        repeat (100) step();
        duty_ch = 2'd1; duty_value = 8'h40; duty_we = 1'b1;
        step();
        total++;
        if (pwm_out[1] !== 1'b1) begin bad++; $display("FAIL mid_write_hold got=%b exp=1", pwm_out[1]); end
        wait_ps(ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL mid_write_wait got=timeout exp=period_start"); end
        measure(hi, len);
        total++;
        if (hi[1] !== 64) begin bad++; $display("FAIL mid_write_new got=%0d exp=64", hi[1]); end
        for (int i = 0; i < 4; i++) begin
            if (i != 1) begin
                total++;
                if (hi[i] !== 127) begin bad++; $display("FAIL mid_write_other ch%0d got=%0d exp=127", i, hi[i]); end
            end
        end
    endtask

    task automatic test_extremes();
        bit ok;
        int hi [4];
        int len;
        duty_ch = 2'd2; duty_value = 8'h00; duty_we = 1'b1;
        step();
        wait_ps(ok);
        measure(hi, len);
        total++;
        if (hi[2] !== 0) begin bad++; $display("FAIL duty_zero got=%0d exp=0", hi[2]); end
        duty_ch = 2'd2; duty_value = 8'hFF; duty_we = 1'b1;
        step();
        wait_ps(ok);
        measure(hi, len);
        total++;
        if (hi[2] !== 255) begin bad++; $display("FAIL duty_full got=%0d exp=255", hi[2]); end
        total++;
        if (len !== 256) begin bad++; $display("FAIL duty_full_period got=%0d exp=256", len); end
    endtask

    task automatic test_wrap_write();
        bit ok;
        int hi [4];
        int len;
        wait_ps(ok);
        repeat (255) step();
        duty_ch = 2'd3; duty_value = 8'h20; duty_we = 1'b1;
        step();
        total++;
        if (period_start !== 1'b1) begin bad++; $display("FAIL wrap_align got=%b exp=1", period_start); end
        measure(hi, len);
        total++;
        if (hi[3] !== 32) begin bad++; $display("FAIL wrap_bypass got=%0d exp=32", hi[3]); end
    endtask

    task automatic test_enable_invert();
        bit ok;
        int hi [4];
        int len;
        repeat (5) step();
        ch_enable[3] = 1'b0;
        step();
        total++;
        if (pwm_out[3] !== 1'b0) begin bad++; $display("FAIL disable_low got=%b exp=0", pwm_out[3]); end
        ch_invert[3] = 1'b1;
        step();
        total++;
        if (pwm_out[3] !== 1'b1) begin bad++; $display("FAIL disable_invert got=%b exp=1", pwm_out[3]); end
        ch_enable = 4'hF; ch_invert = 4'h0;
        repeat (30) step();
        reset = 1'b1;
        step();
        total++;
        if (pwm_out !== 4'b0000 || period_start !== 1'b0) begin
            bad++; $display("FAIL midreset got=%b/%b exp=0000/0", pwm_out, period_start);
        end
        reset = 1'b0;
        wait_ps(ok);
        measure(hi, len);
        total++;
        if (hi[1] !== 127 || hi[2] !== 127 || hi[3] !== 127) begin
            bad++; $display("FAIL midreset_duty got=%0d/%0d/%0d exp=127", hi[1], hi[2], hi[3]);
        end
    endtask

    initial begin
        reset = 1'b1; duty_we = 1'b0; duty_ch = '0; duty_value = '0;
        prescale_we = 1'b0; prescale_value = '0;
        ch_enable = 4'hF; ch_invert = 4'h0;
        #2;
        test_reset();
        test_default_duty();
        test_prescale();
        test_mid_write();
        test_extremes();
        test_wrap_write();
        test_enable_invert();
        @(negedge clk);
        total++;
        if (q.size() !== 0) begin bad++; $display("FAIL queue_drain got=%0d exp=0", q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
